// File: rtl/sd_resp_rx.sv
// -----------------------------------------------------------------------------
// sd_resp_rx
//
// SPI-mode SD card response receiver. It shares the SD bit clock with the
// command sender. After `start` it waits for the first 0 bit on MISO. It then
// shifts in an R1 (8-bit) or R3/R7 (40-bit) response MSB-first. When reception
// ends (or the wait times out) it raises a one-cycle `done` pulse.
//
// Optional feature macro: SD_RESP_TIMEOUT_EN
//   defined   - a wait counter bounds the idle period to MAX_WAIT samples, and
//               `timeout` reports expiry.
//   undefined - WAIT lasts until a 0 arrives, `start`, or reset. `timeout` is
//               tied low.
//
// Parameters:
//   MAX_WAIT   idle (1) samples tolerated in WAIT before timeout, 1..255
//
// Ports:
//   clock      in   SD bit clock, all sampling on the rising edge
//   reset      in   asynchronous active-low reset
//   SDin       in   card data-out (MISO), idles high
//   start      in   single-cycle arm pulse; has priority in every state
//   long_resp  in   sampled with start: 0 = 8-bit R1, 1 = 40-bit R3/R7
//   busy       out  high while waiting for or shifting a response
//   done       out  one-cycle pulse at end of reception or timeout
//   timeout    out  sticky timeout flag, cleared by start or reset
//   r1         out  first received byte (R1 status)
//   response   out  full response, right-aligned (short ones in [7:0])
// -----------------------------------------------------------------------------
module sd_resp_rx #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SDin,
    input  logic        start,
    input  logic        long_resp,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [39:0] response
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("sd_resp_rx: MAX_WAIT must be within 1..255");
    end

    logic [1:0]  r_state;
    logic        r_long;
    logic [5:0]  r_bitcnt;
    logic        r_done;
    logic [7:0]  r_r1;
    logic [39:0] r_resp;

    logic [39:0] w_resp_shift;
    logic        w_last_bit;
    logic        w_r1_bit;

    assign w_resp_shift = {r_resp[38:0], SDin};
    // The bit counter counts down from 8 or 40. Counter value 1 means this edge
    // samples the final bit.
    assign w_last_bit   = (r_bitcnt == 6'd1);
    // The 8th received bit arrives when 33 (long) or 1 (short) bits remain.
    assign w_r1_bit     = (r_bitcnt == (r_long ? 6'd33 : 6'd1));

`ifdef SD_RESP_TIMEOUT_EN
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0] r_waitcnt;
    logic       r_timeout;
    logic [7:0] w_wait_inc;
    logic       w_wait_expire;

    assign w_wait_inc    = r_waitcnt + 8'd1;
    assign w_wait_expire = (w_wait_inc == LP_MAX_WAIT);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_long    <= 1'b0;
            r_bitcnt  <= 6'd0;
            r_done    <= 1'b0;
            r_r1      <= 8'h00;
            r_resp    <= 40'h0;
`ifdef SD_RESP_TIMEOUT_EN
            r_waitcnt <= 8'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (start) begin
                // A restart discards any frame in flight, including one whose
                // final bit lands on this very edge. The SDin sample is ignored.
                r_state   <= S_WAIT;
                r_long    <= long_resp;
                r_bitcnt  <= long_resp ? 6'd40 : 6'd8;
                r_r1      <= 8'h00;
                r_resp    <= 40'h0;
`ifdef SD_RESP_TIMEOUT_EN
                r_waitcnt <= 8'd0;
                r_timeout <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (!SDin) begin
                            // The first 0 is the response MSB and counts as data.
                            r_resp   <= w_resp_shift;
                            r_bitcnt <= r_bitcnt - 6'd1;
                            r_state  <= S_SHIFT;
                        end
`ifdef SD_RESP_TIMEOUT_EN
                        else begin
                            // The counter stops at MAX_WAIT because WAIT is left
                            // on the same edge it gets there.
                            r_waitcnt <= w_wait_inc;
                            if (w_wait_expire) begin
                                r_state   <= S_IDLE;
                                r_timeout <= 1'b1;
                                r_done    <= 1'b1;
                                r_r1      <= 8'hFF;
                                r_resp    <= r_long ? 40'hFF_FFFF_FFFF : 40'h00_0000_00FF;
                            end
                        end
`endif
                    end
                    S_SHIFT: begin
                        r_resp   <= w_resp_shift;
                        r_bitcnt <= r_bitcnt - 6'd1;
                        if (w_r1_bit) begin
                            r_r1 <= w_resp_shift[7:0];
                        end
                        if (w_last_bit) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_IDLE: begin
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy     = (r_state == S_WAIT) || (r_state == S_SHIFT);
    assign done     = r_done;
    assign r1       = r_r1;
    assign response = r_resp;
`ifdef SD_RESP_TIMEOUT_EN
    assign timeout  = r_timeout;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_sd_resp_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_resp_rx
//
// Scoreboard bench for sd_resp_rx. The stimulus tasks push the expected result
// of each frame that should complete. A negedge monitor pops an entry whenever
// `done` is seen and compares the outputs, the completion cycle and the busy
// duration. Timeout scenarios run only when SD_RESP_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sd_resp_rx;

    localparam int MAX_WAIT = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        SDin = 1'b1;
    logic        start = 1'b0;
    logic        long_resp = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  r1;
    logic [39:0] response;

    sd_resp_rx #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .SDin      (SDin),
        .start     (start),
        .long_resp (long_resp),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .r1        (r1),
        .response  (response)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] resp;
        logic [7:0]  r1;
        logic        to;
        int          cyc;
        int          busy_len;
        bit          chk_busy;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_run = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the scoreboard head.
    always @(negedge clock) begin
        if (reset) begin
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
                end else begin
                    m_e = q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(m_e.cyc));
                    check("response",   64'(response), 64'(m_e.resp));
                    check("r1",         64'(r1), 64'(m_e.r1));
                    check("timeout",    64'(timeout), 64'(m_e.to));
                    check("busy_at_done", 64'(busy), 64'h0);
                    if (m_e.chk_busy) check("busy_len", 64'(busy_run), 64'(m_e.busy_len));
                end
            end
            if (busy) busy_run++;
            else      busy_run = 0;
        end
    end

    task automatic drive(input logic st, input logic lr, input logic sd);
        @(negedge clock);
        start     = st;
        long_resp = lr;
        SDin      = sd;
    endtask

    task automatic gap(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'($urandom), 1'($urandom));
    endtask

    // One frame: start, `idle` ones, then the response MSB-first.
    // abort_bits < 0 completes the frame. Otherwise the task returns after that
    // many response bits, and the caller must issue the next start at once.
    task automatic run_frame(input bit lng, input int idle, input logic [39:0] val,
                             input int abort_bits, input logic start_sd, input bit chk_busy);
        int          n;
        logic [39:0] v;
        exp_t        e;
        n = lng ? 40 : 8;
        v = lng ? val : {32'h0, val[7:0]};
        v[n-1] = 1'b0;
        drive(1'b1, lng, start_sd);
        @(posedge clock);
        #1;
        check("start_clr_resp", 64'(response), 64'h0);
        check("start_clr_r1", 64'(r1), 64'h0);
        check("start_clr_timeout", 64'(timeout), 64'h0);
        check("start_busy", 64'(busy), 64'h1);
        for (int i = 0; i < idle; i++) drive(1'b0, 1'($urandom), 1'b1);
        if (abort_bits == 0) return;
        for (int b = 0; b < n; b++) begin
            if (abort_bits > 0 && b == abort_bits) return;
            drive(1'b0, 1'($urandom), v[n-1-b]);
        end
        e.resp     = v;
        e.r1       = lng ? v[39:32] : v[7:0];
        e.to       = 1'b0;
        e.cyc      = cyc + 1;
        e.busy_len = idle + n;
        e.chk_busy = chk_busy;
        q.push_back(e);
    endtask

`ifdef SD_RESP_TIMEOUT_EN
    task automatic run_timeout(input bit lng);
        exp_t e;
        drive(1'b1, lng, 1'($urandom));
        @(posedge clock);
        #1;
        check("start_clr_timeout", 64'(timeout), 64'h0);
        for (int i = 0; i < MAX_WAIT; i++) drive(1'b0, 1'($urandom), 1'b1);
        e.resp     = lng ? 40'hFF_FFFF_FFFF : 40'h00_0000_00FF;
        e.r1       = 8'hFF;
        e.to       = 1'b1;
        e.cyc      = cyc + 1;
        e.busy_len = MAX_WAIT;
        e.chk_busy = 1'b1;
        q.push_back(e);
        gap(3);
        check("timeout_sticky", 64'(timeout), 64'h1);
    endtask
`endif

    bit          f_lng;
    int          f_idle;
    int          f_ab;
    bit          prev_abort;
    logic [63:0] f_rnd;

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_timeout", 64'(timeout), 64'h0);
        check("rst_r1", 64'(r1), 64'h0);
        check("rst_response", 64'(response), 64'h0);
        reset = 1'b1;
        gap(3);

        // R1 after three idle bits
        run_frame(1'b0, 3, 40'h01, -1, 1'b1, 1'b1);
        gap(4);
        // R7 after two idle bits
        run_frame(1'b1, 2, 40'h01_0000_01AA, -1, 1'b1, 1'b1);
        gap(4);
        // restart after 20 bits of a long frame, then R1 0x05
        f_rnd = {$urandom(), $urandom()};
        run_frame(1'b1, 1, f_rnd[39:0], 20, 1'b1, 1'b1);
        run_frame(1'b0, 0, 40'h05, -1, 1'b1, 1'b0);
        gap(4);
        // SDin=0 on the start edge must not begin capture
        run_frame(1'b0, 2, 40'h00, -1, 1'b0, 1'b1);
        gap(4);
        // start lands on the edge carrying the final bit: no done for that frame
        f_rnd = {$urandom(), $urandom()};
        run_frame(1'b0, 1, f_rnd[39:0], 7, 1'b1, 1'b1);
        run_frame(1'b0, 1, 40'h5A, -1, 1'($urandom), 1'b0);
        gap(4);

`ifdef SD_RESP_TIMEOUT_EN
        run_timeout(1'b0);
        run_timeout(1'b1);
        run_frame(1'b0, 4, 40'h33, -1, 1'b1, 1'b1);
        gap(4);
`else
        // idle far longer than MAX_WAIT still completes normally
        run_frame(1'b0, 80, 40'hC3, -1, 1'b1, 1'b1);
        gap(4);
`endif

        prev_abort = 1'b0;
        for (int f = 0; f < 30; f++) begin
            f_lng  = 1'($urandom_range(0, 1));
            f_idle = int'($urandom_range(1, 10));
            f_rnd  = {$urandom(), $urandom()};
            f_ab   = -1;
            if (f != 29 && $urandom_range(0, 4) == 0) f_ab = int'($urandom_range(0, f_lng ? 39 : 7));
            run_frame(f_lng, f_idle, f_rnd[39:0], f_ab, 1'($urandom), !prev_abort);
            prev_abort = (f_ab >= 0);
            if (f_ab < 0) gap(int'($urandom_range(0, 3)));
        end
        gap(4);

        // asynchronous reset in the middle of a long frame
        f_rnd = {$urandom(), $urandom()};
        run_frame(1'b1, 2, f_rnd[39:0], 15, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_busy", 64'(busy), 64'h0);
        check("async_done", 64'(done), 64'h0);
        check("async_timeout", 64'(timeout), 64'h0);
        check("async_r1", 64'(r1), 64'h0);
        check("async_response", 64'(response), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        gap(20);
        check("post_reset_busy", 64'(busy), 64'h0);
        run_frame(1'b0, 1, 40'h7E, -1, 1'b1, 1'b1);
        gap(4);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
        check("queue_drained", 64'(q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sd_resp_rx.md
# sd_resp_rx

SPI-mode SD card response receiver. It sits beside the command sender on the same `clock` and samples the card's data-out line (MISO). After a command frame, it waits for the card's response, which starts with the first 0 bit. It then shifts in an R1 (8-bit) or R3/R7 (40-bit) response MSB-first and presents the result to the controller FSM with a one-cycle `done` pulse.

## Interface
- `MAX_WAIT`, default 64: maximum number of idle (1) samples tolerated in WAIT before timeout; legal range 1..255.
- `clock`  input  1  shared SD bit clock; all sampling on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `SDin`  input  1  card data-out (MISO); idle level 1.
- `start`  input  1  arm receiver; single-cycle pulse, sampled on rising edge.
- `long_resp`  input  1  sampled with `start`: 0 = 8-bit R1, 1 = 40-bit R3/R7.
- `busy`  output  1  high in WAIT and SHIFT.
- `done`  output  1  one-cycle pulse at end of reception or timeout.
- `timeout`  output  1  sticky; set on timeout, cleared by `start` or reset.
- `r1`  output  8  first byte received (R1 status).
- `response`  output  40  full response, right-aligned; short responses occupy [7:0], [39:8] = 0.

## Operation
- States: IDLE, WAIT, SHIFT.
- `reset` low forces all of the following regardless of the clock:
  - IDLE;
  - `busy`=0, `done`=0, `timeout`=0;
  - `r1`=8'h00, `response`=40'h0;
  - all counters = 0.
- `start`=1 has priority in every state, including mid-WAIT and mid-SHIFT. On that edge:
  - enter WAIT;
  - latch `long_resp`;
  - clear `response`, `r1`, `timeout`, and the wait counter;
  - load the bit counter with 8 or 40.
- The `SDin` sample on the `start` edge is ignored.
- WAIT:
  - `SDin`=1: increment the wait counter.
  - Wait counter reaches `MAX_WAIT`: go to IDLE, set `timeout`=1, pulse `done`, force `r1`=8'hFF and `response`=all ones of the selected length (8'hFF or 40'hFF_FFFF_FFFF).
  - `SDin`=0: this sample is response bit MSB (R1 bit 7 is always 0). Shift it in, decrement the bit counter, go to SHIFT.
- SHIFT:
  - Each edge: `response` <= {`response`[38:0], `SDin`} and decrement the bit counter.
  - `SDin` value is irrelevant; zeros and ones are both data.
  - When the 8th received bit is shifted, latch `r1` from the upper byte received so far, i.e. the new `response`[7:0].
- Completion: the edge that samples the final bit (8th or 40th) moves to IDLE and sets `done` for the following cycle only.
- `r1` and `response` hold their values in IDLE until the next `start` or reset.
- Bit counter is 6 bits wide. Wait counter is 8 bits and saturates at `MAX_WAIT`.

## Timing
- Latency: `done` is high in the cycle immediately after the rising edge that samples the last response bit. `response` and `r1` are valid in that same cycle.
- R1 reception takes exactly 8 edges from the first 0 sample; R3/R7 takes exactly 40.
- Timeout: with `SDin` held at 1, `done` and `timeout` rise in the cycle after the `MAX_WAIT`-th WAIT edge, i.e. `MAX_WAIT`+1 edges after `start`.
- `busy` rises in the cycle after `start` and falls in the same cycle `done` rises.
- `done` and `busy` are never high together.
- `start` coincident with a completing edge: restart wins. No `done` is produced, and the result is discarded.
- Reset deasserting mid-frame: the block stays in IDLE; stray `SDin` bits are ignored until `start`.

## Configuration
- `SD_RESP_TIMEOUT_EN`
  - Defined: the wait counter and timeout path exist as described.
  - Undefined: WAIT persists indefinitely until a 0 arrives, `start`, or reset. `timeout` is tied to 0, the wait counter is not built, and `MAX_WAIT` is unused.

## Test plan
- Short response, R1 after idle: `start` with `long_resp`=0, `SDin`=1 for 3 edges, then bits 0000_0001.
  - `done` pulses exactly 8 edges after the first 0 sample.
  - `r1`=8'h01, `response`=40'h00_0000_0001, `timeout`=0.
- Long response, R7: `long_resp`=1, 2 idle bits, then 40'h01_0000_01AA MSB-first.
  - `response`=40'h01_0000_01AA, `r1`=8'h01.
  - `done` fires once; `busy` is high for 42 cycles.
- Timeout (macro defined): `start`, then `SDin` held at 1.
  - `done` and `timeout`=1 in cycle 65 after `start`.
  - `r1`=8'hFF; `busy` falls in that same cycle.
  - A second `start` clears `timeout` on the next edge.
- Restart mid-SHIFT: `start` issued after 20 bits of a 40-bit frame, then a fresh R1 0x05.
  - No `done` for the aborted frame.
  - `r1`=8'h05 and `response`=40'h05 at the single `done`.
- Start collision: `SDin`=0 on the `start` edge, then 1 for 2 edges, then 0x00 with `long_resp`=0.
  - The first 0 is ignored; capture begins at the later 0.
  - `done` fires 8 edges after that 0, with `r1`=8'h00.
- Async reset mid-frame: `reset` pulled low between edges during SHIFT.
  - All outputs are zero immediately, not waiting for a clock edge.
  - After release, `SDin` toggling produces no `done` until the next `start`.
